// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit Harvard pipelined core: bus widths, the
// HALT opcode, the interrupt entry address and the fetch FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] OP_HALT    = 8'hFF;
    localparam logic [ADDR_W-1:0] INT_VECTOR = 8'hF0;
    localparam logic [ADDR_W-1:0] RESET_PC   = 8'h00;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_t;

    // PC increment wraps modulo 2^ADDR_W with no carry out.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + 1'b1;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Bundles the fetch stage's control, instruction-memory and IF/ID signals.
// Optional interrupt signals exist only when FETCH_IRQ_EN is defined.
//   master : the fetch stage itself
//   slave  : the surrounding core (hazard unit, imem, decode, irq source)
// Signals:
//   stall_i, redirect_i, redirect_pc_i   control into fetch
//   imem_addr_o / imem_data_i            instruction memory port
//   ifid_valid_o, ifid_instr_o, ifid_pc_o IF/ID pipeline register
//   halted_o                             fetch stopped on HALT
//   irq_i, irq_done_i, irq_ack_o, epc_o  interrupt handshake (FETCH_IRQ_EN)
// -----------------------------------------------------------------------------
interface fetch_stage_if;
    import cpu_pkg::*;

    logic              stall_i;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [DATA_W-1:0] imem_data_i;
    logic              ifid_valid_o;
    logic [DATA_W-1:0] ifid_instr_o;
    logic [ADDR_W-1:0] ifid_pc_o;
    logic              halted_o;
`ifdef FETCH_IRQ_EN
    logic              irq_i;
    logic              irq_done_i;
    logic              irq_ack_o;
    logic [ADDR_W-1:0] epc_o;
`endif

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, imem_data_i,
`ifdef FETCH_IRQ_EN
        input  irq_i, irq_done_i,
        output irq_ack_o, epc_o,
`endif
        output imem_addr_o, ifid_valid_o, ifid_instr_o, ifid_pc_o, halted_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, imem_data_i,
`ifdef FETCH_IRQ_EN
        output irq_i, irq_done_i,
        input  irq_ack_o, epc_o,
`endif
        input  imem_addr_o, ifid_valid_o, ifid_instr_o, ifid_pc_o, halted_o
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Flush clears valid (instr/pc keep their last
// value, they are don't-care while invalid); hold keeps everything; otherwise
// a new valid instruction is captured. Flush wins over hold.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_hold, i_flush   register control
//   i_instr, i_pc     instruction and its address to capture
//   o_valid, o_instr, o_pc  register contents
// -----------------------------------------------------------------------------
module if_id_reg
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_hold,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_instr,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_pc
);

    logic              r_valid;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, the BOOT/RUN/HALT fetch FSM,
// stall/redirect handling and (optionally) interrupt entry. Feeds decode via
// the if_id_reg sub-module.
// Optional feature macro: FETCH_IRQ_EN (interrupt entry, irq ports, epc).
// Ports:
//   clk    core clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    fetch_stage_if.master (control, imem, IF/ID, halt, irq)
//
// state | meaning
// BOOT  | first cycle after reset, bubble, PC not advanced
// RUN   | fetching one instruction per non-stalled cycle
// HALT  | HALT opcode issued, PC frozen, waiting for redirect
// -----------------------------------------------------------------------------
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC    = cpu_pkg::RESET_PC,
    parameter logic [DATA_W-1:0] HALT_OPCODE = OP_HALT
`ifdef FETCH_IRQ_EN
   ,parameter logic [ADDR_W-1:0] INT_VECTOR  = cpu_pkg::INT_VECTOR
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    localparam logic [1:0] S_BOOT = FS_BOOT;
    localparam logic [1:0] S_RUN  = FS_RUN;
    localparam logic [1:0] S_HALT = FS_HALT;

    logic [ADDR_W-1:0] r_pc;
    logic [1:0]        r_state;
    logic              w_hold;
    logic              w_flush;
    logic              w_take_irq;

`ifdef FETCH_IRQ_EN
    logic              r_in_service;
    logic              r_irq_ack;
    logic [ADDR_W-1:0] r_epc;
`endif

    always_comb begin
        w_take_irq = 1'b0;
`ifdef FETCH_IRQ_EN
        w_take_irq = (r_state == S_RUN) && !bus.redirect_i && !bus.stall_i &&
                     bus.irq_i && !r_in_service;
`endif
        w_hold  = bus.stall_i && !bus.redirect_i;
        // Anything other than a plain RUN fetch leaves a bubble behind it.
        w_flush = bus.redirect_i ||
                  (!bus.stall_i && ((r_state != S_RUN) || w_take_irq));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_state <= S_BOOT;
        end else if (bus.redirect_i) begin
            r_pc    <= bus.redirect_pc_i;
            r_state <= S_RUN;
        end else if (!bus.stall_i) begin
            case (r_state)
                S_BOOT: r_state <= S_RUN;
                S_RUN: begin
                    if (w_take_irq) begin
`ifdef FETCH_IRQ_EN
                        r_pc <= INT_VECTOR;
`endif
                    end else begin
                        r_pc <= pc_inc(r_pc);
                        if (bus.imem_data_i == HALT_OPCODE)
                            r_state <= S_HALT;
                    end
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_BOOT;
            endcase
        end
    end

`ifdef FETCH_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_service <= 1'b0;
            r_irq_ack    <= 1'b0;
            r_epc        <= '0;
        end else begin
            r_irq_ack <= w_take_irq;
            if (w_take_irq) begin
                r_epc        <= r_pc;
                r_in_service <= 1'b1;
            end else if (bus.irq_done_i) begin
                r_in_service <= 1'b0;
            end
        end
    end

    assign bus.irq_ack_o = r_irq_ack;
    assign bus.epc_o     = r_epc;
`endif

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_hold  (w_hold),
        .i_flush (w_flush),
        .i_instr (bus.imem_data_i),
        .i_pc    (r_pc),
        .o_valid (bus.ifid_valid_o),
        .o_instr (bus.ifid_instr_o),
        .o_pc    (bus.ifid_pc_o)
    );

    assign bus.imem_addr_o = r_pc;
    assign bus.halted_o    = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import cpu_pkg::*;

    typedef struct {
        logic       stall;
        logic       redir;
        logic [7:0] rpc;
        logic       e_valid;
        logic [7:0] e_instr;
        logic [7:0] e_pc;
        logic [7:0] e_addr;
        logic       e_halt;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] imem [256];
    assign bus.imem_data_i = imem[bus.imem_addr_o];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_init(input logic [7:0] a);
        case (a)
            8'h00:   return 8'h11;
            8'h01:   return 8'h22;
            8'h02:   return 8'h33;
            8'h03:   return 8'hFF;
            default: return a ^ 8'hA5;
        endcase
    endfunction

    vec_t tbl [19];
    vec_t sb_q [$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic set_v(input int i, input logic st, input logic rd, input logic [7:0] rpc,
                         input logic ev, input logic [7:0] ep, input logic [7:0] ea,
                         input logic eh);
        tbl[i].stall   = st;
        tbl[i].redir   = rd;
        tbl[i].rpc     = rpc;
        tbl[i].e_valid = ev;
        tbl[i].e_pc    = ep;
        tbl[i].e_instr = mem_init(ep);
        tbl[i].e_addr  = ea;
        tbl[i].e_halt  = eh;
    endtask

    // Called at a negedge: drive, queue expectation, sample 1 time unit after posedge.
    task automatic apply(input string nm, input vec_t v);
        vec_t e;
        bus.stall_i       = v.stall;
        bus.redirect_i    = v.redir;
        bus.redirect_pc_i = v.rpc;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_queue: got empty expected entry", nm);
        end else begin
            e = sb_q.pop_front();
            chk({nm, "_valid"}, {7'd0, bus.ifid_valid_o}, {7'd0, e.e_valid});
            chk({nm, "_addr"}, bus.imem_addr_o, e.e_addr);
            chk({nm, "_halted"}, {7'd0, bus.halted_o}, {7'd0, e.e_halt});
            if (e.e_valid) begin
                chk({nm, "_instr"}, bus.ifid_instr_o, e.e_instr);
                chk({nm, "_pc"}, bus.ifid_pc_o, e.e_pc);
            end
        end
        @(negedge clk);
        bus.stall_i    = 1'b0;
        bus.redirect_i = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_valid"}, {7'd0, bus.ifid_valid_o}, 8'h00);
        chk({nm, "_instr"}, bus.ifid_instr_o, 8'h00);
        chk({nm, "_pc"}, bus.ifid_pc_o, 8'h00);
        chk({nm, "_addr"}, bus.imem_addr_o, 8'h00);
        chk({nm, "_halted"}, {7'd0, bus.halted_o}, 8'h00);
`ifdef FETCH_IRQ_EN
        chk({nm, "_ack"}, {7'd0, bus.irq_ack_o}, 8'h00);
        chk({nm, "_epc"}, bus.epc_o, 8'h00);
`endif
    endtask

    initial begin
        vec_t v;
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) imem[i] = mem_init(8'(i));

        //       idx st rd rpc    valid pc     addr   halt
        set_v( 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0);   // BOOT bubble
        set_v( 1, 0, 0, 8'h00, 1, 8'h00, 8'h01, 0);   // 11@00
        set_v( 2, 0, 0, 8'h00, 1, 8'h01, 8'h02, 0);   // 22@01
        set_v( 3, 0, 0, 8'h00, 1, 8'h02, 8'h03, 0);   // 33@02
        set_v( 4, 0, 0, 8'h00, 1, 8'h03, 8'h04, 1);   // HALT issued valid
        set_v( 5, 0, 0, 8'h00, 0, 8'h03, 8'h04, 1);   // halted, frozen
        set_v( 6, 0, 0, 8'h00, 0, 8'h03, 8'h04, 1);
        set_v( 7, 0, 1, 8'h04, 0, 8'h00, 8'h04, 0);   // redirect out of HALT
        set_v( 8, 0, 0, 8'h00, 1, 8'h04, 8'h05, 0);
        set_v( 9, 1, 0, 8'h00, 1, 8'h04, 8'h05, 0);   // stall at PC=5
        set_v(10, 1, 0, 8'h00, 1, 8'h04, 8'h05, 0);
        set_v(11, 1, 0, 8'h00, 1, 8'h04, 8'h05, 0);
        set_v(12, 0, 0, 8'h00, 1, 8'h05, 8'h06, 0);   // resumes with 5
        set_v(13, 1, 1, 8'h40, 0, 8'h00, 8'h40, 0);   // redirect beats stall
        set_v(14, 0, 0, 8'h00, 1, 8'h40, 8'h41, 0);
        set_v(15, 0, 1, 8'hFE, 0, 8'h00, 8'hFE, 0);
        set_v(16, 0, 0, 8'h00, 1, 8'hFE, 8'hFF, 0);
        set_v(17, 0, 0, 8'h00, 1, 8'hFF, 8'h00, 0);   // PC wraps
        set_v(18, 0, 0, 8'h00, 1, 8'h00, 8'h01, 0);

        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 8'h00;
`ifdef FETCH_IRQ_EN
        bus.irq_i         = 1'b0;
        bus.irq_done_i    = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) apply($sformatf("vec%0d", i), tbl[i]);

        // Asynchronous reset mid-run (IF/ID currently valid).
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Redirect honoured during the BOOT cycle.
        v = '{stall:0, redir:1, rpc:8'h20, e_valid:0, e_instr:8'h00, e_pc:8'h00,
              e_addr:8'h20, e_halt:0};
        apply("boot_redir", v);
        v = '{stall:0, redir:0, rpc:8'h00, e_valid:1, e_instr:mem_init(8'h20), e_pc:8'h20,
              e_addr:8'h21, e_halt:0};
        apply("boot_redir_fetch", v);

`ifdef FETCH_IRQ_EN
        v = '{stall:0, redir:1, rpc:8'h07, e_valid:0, e_instr:8'h00, e_pc:8'h00,
              e_addr:8'h07, e_halt:0};
        apply("irq_goto7", v);
        bus.irq_i = 1'b1;
        @(posedge clk);
        #1;
        chk("irq_ack", {7'd0, bus.irq_ack_o}, 8'h01);
        chk("irq_epc", bus.epc_o, 8'h07);
        chk("irq_addr", bus.imem_addr_o, 8'hF0);
        chk("irq_valid", {7'd0, bus.ifid_valid_o}, 8'h00);
        @(posedge clk);
        #1;
        chk("irq2_ack", {7'd0, bus.irq_ack_o}, 8'h00);
        chk("irq2_pc", bus.ifid_pc_o, 8'hF0);
        chk("irq2_instr", bus.ifid_instr_o, mem_init(8'hF0));
        chk("irq2_addr", bus.imem_addr_o, 8'hF1);
        @(negedge clk);
        bus.irq_i      = 1'b0;
        bus.irq_done_i = 1'b1;
        @(negedge clk);
        bus.irq_done_i = 1'b0;
        bus.irq_i      = 1'b1;
        @(posedge clk);
        #1;
        chk("irq3_ack", {7'd0, bus.irq_ack_o}, 8'h01);
        chk("irq3_epc", bus.epc_o, 8'hF2);
        chk("irq3_addr", bus.imem_addr_o, 8'hF0);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("irq_rst");
        bus.irq_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
